dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares one single-port, synchronous-read data memory (dMem) between the core load/store port and a debug/loader port.
//  Sits between the datapath data-memory interface and the dMem instance.
//  Stalls the core while its access is pending. Core has priority; the debug port has a starvation limit.
//  Single outstanding access; memory read data returns 1 cycle after issue.
// PARAMETERS
//  ADDR_W      32  address width, all ports
//  DATA_W      32  data width, all ports
//  STARVE_LIM  4   cycles a denied dbg_req waits before it wins priority over core_req (>=1)
// PORTS
//  clock       in   1       system clock, all logic on rising edge
//  rstn        in   1       synchronous reset, active low
//  core_req    in   1       core requests access; held with stable fields until core_stall=0
//  core_we     in   1       1=write, 0=read
//  core_addr   in   ADDR_W  core address
//  core_wdata  in   DATA_W  core write data
//  core_rdata  out  DATA_W  read data, valid when core_stall=0 in S_CORE_RD, else 0
//  core_stall  out  1       1 = core must hold PC/state this cycle
//  dbg_req     in   1       debug requests access; held with stable fields until dbg_gnt
//  dbg_we      in   1       1=write, 0=read
//  dbg_addr    in   ADDR_W  debug address
//  dbg_wdata   in   DATA_W  debug write data
//  dbg_gnt     out  1       1-cycle pulse: debug access issued this cycle
//  dbg_rdata   out  DATA_W  read data, valid with dbg_rvalid, else 0
//  dbg_rvalid  out  1       1-cycle pulse, cycle after a debug read grant
//  mem_en      out  1       memory access strobe
//  mem_we      out  1       memory write enable (only with mem_en)
//  mem_addr    out  ADDR_W  memory address (0 when mem_en=0)
//  mem_wdata   out  DATA_W  memory write data (0 when mem_en=0)
//  mem_rdata   in   DATA_W  memory read data, 1 cycle after read issue
// BEHAVIOUR
//  Reset: synchronous, active low. While rstn=0: state=S_IDLE, starve_cnt=0.
//   All outputs are 0, except core_stall=core_req.
//  FSM states: S_IDLE (may issue), S_CORE_RD (core read data returning), S_DBG_RD (debug read data returning).
//  Issue happens only in S_IDLE. Winner selection, in priority order:
//   1. dbg_req & starve_cnt==STARVE_LIM -> debug
//   2. core_req -> core
//   3. dbg_req -> debug
//   4. otherwise no access
//  Issue cycle: mem_en=1 and mem_we/addr/wdata come from the winner (combinational).
//   Debug win: dbg_gnt=1.
//  Core write: completes in the issue cycle, core_stall=0. Next state S_IDLE.
//  Core read: core_stall=1 in the issue cycle, next state S_CORE_RD.
//   In S_CORE_RD: core_rdata=mem_rdata, core_stall=0, next state S_IDLE.
//   Read throughput is 1 access per 2 cycles.
//  Debug write: next state S_IDLE. Debug read: next state S_DBG_RD.
//   In S_DBG_RD: dbg_rvalid=1, dbg_rdata=mem_rdata, next state S_IDLE.
//  core_stall=1 whenever core_req=1 and the core is not completing this cycle.
//   This includes when debug wins and during S_DBG_RD.
//  No issue in S_CORE_RD or S_DBG_RD. mem_en=0 in those states.
//  starve_cnt:
//   Clears when dbg_req=0 or dbg_gnt=1.
//   Otherwise increments each cycle with dbg_req=1 and dbg_gnt=0, saturating at STARVE_LIM.
//  Simultaneous core_req and dbg_req with starve_cnt<STARVE_LIM: core wins and starve_cnt increments.
//  A request arriving in a RD state waits for S_IDLE. No request is dropped or reordered within a port.
//  Reset during S_CORE_RD or S_DBG_RD: read is discarded, no dbg_rvalid, core_stall follows core_req.
//  Read-after-write to the same address returns the new data (the write is issued in an earlier cycle).
//  Address/data widths pass through unchanged. No alignment checks; the datapath owns alignment.
// TESTING
//  1. Reset: rstn=0 for 2 cycles with core_req=1 -> all mem_* outputs 0, core_stall=1, dbg_gnt=0.
//  2. Core write then read: core writes 0xDEADBEEF @0x10 (stall=0, mem_we=1), then reads @0x10
//     -> stall=1, then stall=0 with core_rdata=0xDEADBEEF.
//  3. Simultaneous requests, STARVE_LIM=4: core_req held continuously, dbg read @0x20
//     -> core wins until starve_cnt=4, then dbg_gnt pulses, dbg_rvalid next cycle with the memory value.
//  4. Debug-only traffic: dbg writes 0x1234 @0x8 then reads @0x8 -> gnt, gnt, rvalid with dbg_rdata=0x1234.
//  5. Reset mid-read: assert rstn=0 in the S_DBG_RD cycle -> dbg_rvalid=0; after release the FSM restarts in S_IDLE.
//  6. Back-to-back core reads @0x0,@0x4 -> issue/data/issue/data with mem_en pattern 1,0,1,0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbitrates one single-port, synchronous-read data memory between the core load/store port
// and a debug/loader port. Core has priority; debug wins after STARVE_LIM denied cycles.
module dmem_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic              clock,
   input  logic              rstn,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CntW = $clog2(STARVE_LIM + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIM);

   typedef enum logic [1:0] {StIdle, StCoreRd, StDbgRd} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] starve_q, starve_d;
   logic            dbg_prio, core_win, dbg_win;

   always_comb begin
      dbg_prio = dbg_req && (starve_q == CntMax);
      core_win = core_req && !dbg_prio;
      dbg_win  = dbg_req && (dbg_prio || !core_req);
   end

   always_ff @(posedge clock) begin
      if (!rstn) begin
         state_q  <= StIdle;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (core_win && !core_we) begin
               state_d = StCoreRd;
            end else if (dbg_win && !dbg_we) begin
               state_d = StDbgRd;
            end
         end
         StCoreRd: state_d = StIdle;
         StDbgRd:  state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Counts every denied debug cycle, including cycles spent in a read-return state.
   always_comb begin
      starve_d = starve_q;
      if (!dbg_req || dbg_gnt) begin
         starve_d = '0;
      end else if (starve_q != CntMax) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // Everything except core_stall is forced low while reset is asserted.
   always_comb begin
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      core_rdata = '0;
      core_stall = core_req;
      dbg_gnt    = 1'b0;
      dbg_rdata  = '0;
      dbg_rvalid = 1'b0;
      if (rstn) begin
         unique case (state_q)
            StIdle: begin
               if (core_win) begin
                  mem_en     = 1'b1;
                  mem_we     = core_we;
                  mem_addr   = core_addr;
                  mem_wdata  = core_wdata;
                  core_stall = !core_we;
               end else if (dbg_win) begin
                  mem_en    = 1'b1;
                  mem_we    = dbg_we;
                  mem_addr  = dbg_addr;
                  mem_wdata = dbg_wdata;
                  dbg_gnt   = 1'b1;
               end
            end
            StCoreRd: begin
               core_rdata = mem_rdata;
               core_stall = 1'b0;
            end
            StDbgRd: begin
               dbg_rvalid = 1'b1;
               dbg_rdata  = mem_rdata;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter with a small synchronous-read memory attached.
module tb_dmem_arbiter;

   typedef struct {
      logic        rstn;
      logic        creq;
      logic        cwe;
      logic [31:0] caddr;
      logic [31:0] cwdata;
      logic        dreq;
      logic        dwe;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic        en;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        stall;
      logic [31:0] crdata;
      logic        gnt;
      logic        rvalid;
      logic [31:0] drdata;
   } vec_t;

   logic        clock = 1'b0;
   logic        rstn;
   logic        core_req, core_we, dbg_req, dbg_we;
   logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
   logic [31:0] core_rdata, dbg_rdata;
   logic        core_stall, dbg_gnt, dbg_rvalid;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic [31:0] mem [0:63];

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   always #5 clock = ~clock;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4)) dut (
      .clock      (clock),
      .rstn       (rstn),
      .core_req   (core_req),
      .core_we    (core_we),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_rdata (core_rdata),
      .core_stall (core_stall),
      .dbg_req    (dbg_req),
      .dbg_we     (dbg_we),
      .dbg_addr   (dbg_addr),
      .dbg_wdata  (dbg_wdata),
      .dbg_gnt    (dbg_gnt),
      .dbg_rdata  (dbg_rdata),
      .dbg_rvalid (dbg_rvalid),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Single-port memory, read data one cycle after issue.
   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr[7:2]];
      end
   end

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clock);
      rstn       = v.rstn;
      core_req   = v.creq;
      core_we    = v.cwe;
      core_addr  = v.caddr;
      core_wdata = v.cwdata;
      dbg_req    = v.dreq;
      dbg_we     = v.dwe;
      dbg_addr   = v.daddr;
      dbg_wdata  = v.dwdata;
      #1;
      chk("mem_en", idx, 32'(mem_en), 32'(v.en));
      chk("mem_we", idx, 32'(mem_we), 32'(v.we));
      chk("mem_addr", idx, mem_addr, v.addr);
      chk("mem_wdata", idx, mem_wdata, v.wdata);
      chk("core_stall", idx, 32'(core_stall), 32'(v.stall));
      chk("core_rdata", idx, core_rdata, v.crdata);
      chk("dbg_gnt", idx, 32'(dbg_gnt), 32'(v.gnt));
      chk("dbg_rvalid", idx, 32'(dbg_rvalid), 32'(v.rvalid));
      chk("dbg_rdata", idx, dbg_rdata, v.drdata);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      rstn = 1'b0; core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

      // {rstn, creq,cwe,caddr,cwdata, dreq,dwe,daddr,dwdata,
      //  en,we,addr,wdata, stall,crdata, gnt,rvalid,drdata}
      // Reset held with core_req=1
      vecs.push_back('{0, 1,0,32'h0,32'h0, 0,0,32'h0,32'h0,
                       0,0,32'h0,32'h0, 1,32'h0, 0,0,32'h0});
      vecs.push_back('{0, 1,0,32'h0,32'h0, 0,0,32'h0,32'h0,
                       0,0,32'h0,32'h0, 1,32'h0, 0,0,32'h0});
      // Core write then read @0x10
      vecs.push_back('{1, 1,1,32'h10,32'hDEADBEEF, 0,0,32'h0,32'h0,
                       1,1,32'h10,32'hDEADBEEF, 0,32'h0, 0,0,32'h0});
      vecs.push_back('{1, 1,0,32'h10,32'h0, 0,0,32'h0,32'h0,
                       1,0,32'h10,32'h0, 1,32'h0, 0,0,32'h0});
      vecs.push_back('{1, 1,0,32'h10,32'h0, 0,0,32'h0,32'h0,
                       0,0,32'h0,32'h0, 0,32'hDEADBEEF, 0,0,32'h0});
      // Preload 0x20
      vecs.push_back('{1, 1,1,32'h20,32'hCAFE0020, 0,0,32'h0,32'h0,
                       1,1,32'h20,32'hCAFE0020, 0,32'h0, 0,0,32'h0});
      // Contention: core writes win 4 times, then the starved debug read wins
      for (int k = 1; k <= 4; k++) begin
         vecs.push_back('{1, 1,1,32'h40,32'(k), 1,0,32'h20,32'h0,
                          1,1,32'h40,32'(k), 0,32'h0, 0,0,32'h0});
      end
      vecs.push_back('{1, 1,1,32'h40,32'h5, 1,0,32'h20,32'h0,
                       1,0,32'h20,32'h0, 1,32'h0, 1,0,32'h0});
      vecs.push_back('{1, 1,1,32'h40,32'h5, 0,0,32'h0,32'h0,
                       0,0,32'h0,32'h0, 1,32'h0, 0,1,32'hCAFE0020});
      vecs.push_back('{1, 1,1,32'h40,32'h5, 0,0,32'h0,32'h0,
                       1,1,32'h40,32'h5, 0,32'h0, 0,0,32'h0});
      // Debug-only write then read @0x8
      vecs.push_back('{1, 0,0,32'h0,32'h0, 1,1,32'h8,32'h1234,
                       1,1,32'h8,32'h1234, 0,32'h0, 1,0,32'h0});
      vecs.push_back('{1, 0,0,32'h0,32'h0, 1,0,32'h8,32'h0,
                       1,0,32'h8,32'h0, 0,32'h0, 1,0,32'h0});
      vecs.push_back('{1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0,
                       0,0,32'h0,32'h0, 0,32'h0, 0,1,32'h1234});
      // Back-to-back core reads @0x0, @0x4
      vecs.push_back('{1, 1,1,32'h0,32'h11110000, 0,0,32'h0,32'h0,
                       1,1,32'h0,32'h11110000, 0,32'h0, 0,0,32'h0});
      vecs.push_back('{1, 1,1,32'h4,32'h22224444, 0,0,32'h0,32'h0,
                       1,1,32'h4,32'h22224444, 0,32'h0, 0,0,32'h0});
      vecs.push_back('{1, 1,0,32'h0,32'h0, 0,0,32'h0,32'h0,
                       1,0,32'h0,32'h0, 1,32'h0, 0,0,32'h0});
      vecs.push_back('{1, 1,0,32'h0,32'h0, 0,0,32'h0,32'h0,
                       0,0,32'h0,32'h0, 0,32'h11110000, 0,0,32'h0});
      vecs.push_back('{1, 1,0,32'h4,32'h0, 0,0,32'h0,32'h0,
                       1,0,32'h4,32'h0, 1,32'h0, 0,0,32'h0});
      vecs.push_back('{1, 1,0,32'h4,32'h0, 0,0,32'h0,32'h0,
                       0,0,32'h0,32'h0, 0,32'h22224444, 0,0,32'h0});
      vecs.push_back('{1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0,
                       0,0,32'h0,32'h0, 0,32'h0, 0,0,32'h0});

      foreach (vecs[i]) apply(vecs[i], i);

      // Reset in the debug read-return cycle discards the read; FSM restarts idle
      apply('{1, 0,0,32'h0,32'h0, 1,0,32'h8,32'h0,
              1,0,32'h8,32'h0, 0,32'h0, 1,0,32'h0}, 100);
      apply('{0, 1,0,32'h8,32'h0, 0,0,32'h0,32'h0,
              0,0,32'h0,32'h0, 1,32'h0, 0,0,32'h0}, 101);
      apply('{1, 1,0,32'h8,32'h0, 0,0,32'h0,32'h0,
              1,0,32'h8,32'h0, 1,32'h0, 0,0,32'h0}, 102);
      apply('{1, 1,0,32'h8,32'h0, 0,0,32'h0,32'h0,
              0,0,32'h0,32'h0, 0,32'h1234, 0,0,32'h0}, 103);
      apply('{1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0,
              0,0,32'h0,32'h0, 0,32'h0, 0,0,32'h0}, 104);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
